// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the multi-cycle control unit and the datapath/memory.
//   master : controller side (receives IR fields, ALU zero flag and mem_ack; drives
//            memory request, register write enables and datapath selects)
//   slave  : datapath/memory side (the mirror image)
// Signals
//   op, funct      IR[31:26] / IR[5:0]
//   zero           ALU zero flag
//   mem_ack        memory completed the current access this cycle
//   mem_req, iord, mem_wr              memory port control
//   ir_wr, pc_wr, pc_src               IR/PC load controls
//   reg_wr, reg_dst, mem2reg           register file write controls
//   alu_src_a, alu_src_b, ext, alu_ctrl ALU operand selects and operation
//   state, err                         debug state and sticky error code
interface mc_ctrl_if #(
   parameter int ALU_OP_W = 5
);
   logic [5:0]          op;
   logic [5:0]          funct;
   logic                zero;
   logic                mem_ack;
   logic                mem_req;
   logic                iord;
   logic                mem_wr;
   logic                ir_wr;
   logic                pc_wr;
   logic [1:0]          pc_src;
   logic                reg_wr;
   logic [1:0]          reg_dst;
   logic [1:0]          mem2reg;
   logic [1:0]          alu_src_a;
   logic [1:0]          alu_src_b;
   logic                ext;
   logic [ALU_OP_W-1:0] alu_ctrl;
   logic [2:0]          state;
   logic [1:0]          err;

   modport master (
      input  op, funct, zero, mem_ack,
      output mem_req, iord, mem_wr, ir_wr, pc_wr, pc_src, reg_wr, reg_dst, mem2reg,
             alu_src_a, alu_src_b, ext, alu_ctrl, state, err
   );

   modport slave (
      output op, funct, zero, mem_ack,
      input  mem_req, iord, mem_wr, ir_wr, pc_wr, pc_src, reg_wr, reg_dst, mem2reg,
             alu_src_a, alu_src_b, ext, alu_ctrl, state, err
   );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit. Sequences IF/ID/EX/MEM/WB (plus BR, JMP
// and a sticky ERR state) over a shared ALU and a single memory port with a
// mem_req/mem_ack handshake guarded by a watchdog.
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset; every output reads 0 while it is high
//   bus   mc_ctrl_if.master (IR fields, zero, mem_ack in; all controls out)
// Parameters
//   ALU_OP_W  alu_ctrl width (codes zero-extended)
//   MEM_TO    wait cycles tolerated on mem_ack before a timeout (1..255)
//   CNT_W     watchdog counter width
// Build option
//   MC_CTRL_JAL_EN  adds JAL (op 000011) and JR (R funct 001000); without it both
//                   encodings decode as illegal.
module mc_ctrl #(
   parameter int ALU_OP_W = 5,
   parameter int MEM_TO   = 15,
   parameter int CNT_W    = 8
) (
   input logic       clk,
   input logic       rst,
   mc_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_MEM = 3'd3,
      ST_WB = 3'd4, ST_BR = 3'd5, ST_JMP = 3'd6, ST_ERR = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_R, C_IMM, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_ILL
   } cls_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_JAL_EN
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;
`endif

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SRL = 4'd3;
   localparam logic [3:0] ALU_SLT = 4'd4, ALU_AND = 4'd5, ALU_OR = 4'd6, ALU_XOR = 4'd7;
   localparam logic [3:0] ALU_SLTU = 4'd8, ALU_SRA = 4'd9, ALU_NOR = 4'd10, ALU_BAD = 4'd15;

   // R-type funct to ALU code; anything not listed maps to ALU_BAD and is illegal
   function automatic logic [3:0] r_alu(input logic [5:0] f);
      logic [3:0] code;
      case (f)
         6'b100000, 6'b100001: code = ALU_ADD;
         6'b100010, 6'b100011: code = ALU_SUB;
         6'b000000:            code = ALU_SLL;
         6'b000010:            code = ALU_SRL;
         6'b000011:            code = ALU_SRA;
         6'b100100:            code = ALU_AND;
         6'b100101:            code = ALU_OR;
         6'b100110:            code = ALU_XOR;
         6'b100111:            code = ALU_NOR;
         6'b101010:            code = ALU_SLT;
         6'b101011:            code = ALU_SLTU;
         default:              code = ALU_BAD;
      endcase
      return code;
   endfunction

   // ALU code for immediate forms; LUI is an SLL of the immediate by 16
   function automatic logic [3:0] i_alu(input logic [5:0] o);
      logic [3:0] code;
      case (o)
         OP_SLTI:  code = ALU_SLT;
         OP_SLTIU: code = ALU_SLTU;
         OP_ANDI:  code = ALU_AND;
         OP_ORI:   code = ALU_OR;
         OP_XORI:  code = ALU_XOR;
         OP_LUI:   code = ALU_SLL;
         default:  code = ALU_ADD;
      endcase
      return code;
   endfunction

   // Instruction class; ADDI is deliberately absent so it decodes as illegal
   function automatic cls_t decode(input logic [5:0] o, input logic [5:0] f);
      cls_t c;
      c = C_ILL;
      case (o)
         OP_RTYPE: begin
            if (r_alu(f) != ALU_BAD) c = C_R;
`ifdef MC_CTRL_JAL_EN
            if (f == FN_JR) c = C_JR;
`endif
         end
         OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: c = C_IMM;
         OP_LW:          c = C_LW;
         OP_SW:          c = C_SW;
         OP_BEQ, OP_BNE: c = C_BR;
         OP_J:           c = C_J;
`ifdef MC_CTRL_JAL_EN
         OP_JAL:         c = C_JAL;
`endif
         default:        c = C_ILL;
      endcase
      return c;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [1:0]       err_q, err_d;
   logic [5:0]       op_q, funct_q;
   cls_t             cls_id, cls_q;

   logic             mem_req, iord, mem_wr, ir_wr, pc_wr, reg_wr, ext;
   logic [1:0]       pc_src, reg_dst, mem2reg, alu_src_a, alu_src_b, err_o;
   logic [3:0]       alu_code;
   logic [2:0]       state_o;

   assign cls_id = decode(bus.op, bus.funct);
   assign cls_q  = decode(op_q, funct_q);

   // State, watchdog and error registers; the IR fields are captured during ID
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IF;
         cnt     <= '0;
         err_q   <= 2'b00;
         op_q    <= '0;
         funct_q <= '0;
      end else begin
         state_q <= state_d;
         cnt     <= cnt_d;
         err_q   <= err_d;
         if (state_q == ST_ID) begin
            op_q    <= bus.op;
            funct_q <= bus.funct;
         end
      end
   end

   // Next state; the counter only runs while a memory access waits, so it is
   // already zero on entry to IF/MEM, and an ack on the limit cycle still wins
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      cnt_d   = '0;
      case (state_q)
         ST_IF, ST_MEM: begin
            if (bus.mem_ack) begin
               if (state_q == ST_IF)    state_d = ST_ID;
               else if (cls_q == C_LW)  state_d = ST_WB;
               else                     state_d = ST_IF;
            end else if (cnt == CNT_W'(MEM_TO)) begin
               state_d = ST_ERR;
               err_d   = 2'b10;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_ID: begin
            case (cls_id)
               C_R, C_IMM, C_LW, C_SW: state_d = ST_EX;
               C_BR:                   state_d = ST_BR;
               C_J, C_JAL, C_JR:       state_d = ST_JMP;
               default: begin
                  state_d = ST_ERR;
                  err_d   = 2'b01;
               end
            endcase
         end
         ST_EX:                 state_d = (cls_q == C_LW || cls_q == C_SW) ? ST_MEM : ST_WB;
         ST_WB, ST_BR, ST_JMP:  state_d = ST_IF;
         default:               state_d = ST_ERR;
      endcase
   end

   // Outputs decoded from state and the latched IR; everything reads 0 during reset
   always_comb begin
      mem_req   = 1'b0;
      iord      = 1'b0;
      mem_wr    = 1'b0;
      ir_wr     = 1'b0;
      pc_wr     = 1'b0;
      pc_src    = 2'b00;
      reg_wr    = 1'b0;
      reg_dst   = 2'b00;
      mem2reg   = 2'b00;
      alu_src_a = 2'b00;
      alu_src_b = 2'b00;
      ext       = 1'b0;
      alu_code  = ALU_ADD;
      state_o   = 3'd0;
      err_o     = 2'b00;
      if (!rst) begin
         state_o = state_q;
         err_o   = err_q;
         case (state_q)
            ST_IF: begin
               mem_req   = 1'b1;
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               if (bus.mem_ack) begin
                  ir_wr = 1'b1;
                  pc_wr = 1'b1;
               end
            end
            ST_ID: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b11;
               ext       = 1'b1;
            end
            ST_EX: begin
               if (cls_q == C_R) begin
                  alu_code  = r_alu(funct_q);
                  alu_src_a = (alu_code == ALU_SLL || alu_code == ALU_SRL || alu_code == ALU_SRA)
                              ? 2'b01 : 2'b00;
               end else begin
                  alu_code  = i_alu(op_q);
                  alu_src_a = (op_q == OP_LUI) ? 2'b01 : 2'b00;
                  alu_src_b = 2'b10;
                  ext       = (op_q == OP_ADDIU) || (op_q == OP_SLTI) ||
                              (cls_q == C_LW) || (cls_q == C_SW);
               end
            end
            ST_MEM: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               mem_wr  = (cls_q == C_SW);
            end
            ST_WB: begin
               reg_wr  = 1'b1;
               reg_dst = (cls_q == C_R) ? 2'b01 : 2'b00;
               mem2reg = (cls_q == C_LW) ? 2'b01 : 2'b00;
            end
            ST_BR: begin
               alu_code = ALU_SUB;
               pc_wr    = bus.zero ^ (op_q == OP_BNE);
               pc_src   = 2'b01;
            end
            ST_JMP: begin
               pc_wr  = 1'b1;
               pc_src = 2'b10;
`ifdef MC_CTRL_JAL_EN
               if (cls_q == C_JR) pc_src = 2'b11;
               if (cls_q == C_JAL) begin
                  reg_wr  = 1'b1;
                  reg_dst = 2'b10;
                  mem2reg = 2'b10;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_req   = mem_req;
   assign bus.iord      = iord;
   assign bus.mem_wr    = mem_wr;
   assign bus.ir_wr     = ir_wr;
   assign bus.pc_wr     = pc_wr;
   assign bus.pc_src    = pc_src;
   assign bus.reg_wr    = reg_wr;
   assign bus.reg_dst   = reg_dst;
   assign bus.mem2reg   = mem2reg;
   assign bus.alu_src_a = alu_src_a;
   assign bus.alu_src_b = alu_src_b;
   assign bus.ext       = ext;
   assign bus.alu_ctrl  = ALU_OP_W'(alu_code);
   assign bus.state     = state_o;
   assign bus.err       = err_o;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Each instruction is expanded into
// its expected per-cycle output script (from the instruction class, planned
// memory wait counts and the timeout limit); the script also carries the inputs
// to drive. A negedge process compares every cycle against the script.
module tb_mc_ctrl;

   localparam int MEM_TO = 4;

   localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
   localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

   typedef struct packed {
      logic [2:0] state;
      logic [1:0] err;
      logic       mem_req, iord, mem_wr, ir_wr, pc_wr;
      logic [1:0] pc_src;
      logic       reg_wr;
      logic [1:0] reg_dst, mem2reg, alu_src_a, alu_src_b;
      logic       ext;
      logic [4:0] alu_ctrl;
   } outv_t;

   typedef struct packed {
      logic       rst, ack, zero;
      logic [5:0] op, funct;
      outv_t      o;
   } cyc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mc_ctrl_if #(.ALU_OP_W(5)) bif ();

   mc_ctrl #(.ALU_OP_W(5), .MEM_TO(MEM_TO), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   cyc_t       expq[$];
   cyc_t       cur;
   logic       curValid = 1'b0;
   logic [5:0] curOp = '0, curFunct = '0;
   logic [1:0] modelErr = 2'b00;
   int         checks = 0, errors = 0, cycleNo = 0;

   logic [5:0] opTab [0:17] = '{6'b000000, 6'b000000, 6'b000000, 6'b001001, 6'b001010,
                                6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
                                6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                                6'b000011, 6'b111111, 6'b001000};
   logic [5:0] fnTab [0:15] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                6'b000000, 6'b000010, 6'b000011, 6'b001000, 6'b000001,
                                6'b000100};

   // Instruction class and EX-cycle ALU setup as listed by the instruction set
   function automatic void expectKind(input logic [5:0] op, input logic [5:0] fn,
                                      output int kind, output logic [4:0] alu,
                                      output logic ext, output logic [1:0] a);
      kind = K_ILL; alu = 5'd0; ext = 1'b0; a = 2'b00;
      if (op == 6'b000000) begin
         kind = K_R;
         case (fn)
            6'b100000, 6'b100001: alu = 5'd0;
            6'b100010, 6'b100011: alu = 5'd1;
            6'b000000: begin alu = 5'd2; a = 2'b01; end
            6'b000010: begin alu = 5'd3; a = 2'b01; end
            6'b000011: begin alu = 5'd9; a = 2'b01; end
            6'b101010: alu = 5'd4;
            6'b100100: alu = 5'd5;
            6'b100101: alu = 5'd6;
            6'b100110: alu = 5'd7;
            6'b101011: alu = 5'd8;
            6'b100111: alu = 5'd10;
`ifdef MC_CTRL_JAL_EN
            6'b001000: kind = K_JR;
`endif
            default:   kind = K_ILL;
         endcase
      end else begin
         case (op)
            6'b001001: begin kind = K_I; alu = 5'd0; ext = 1'b1; end
            6'b001010: begin kind = K_I; alu = 5'd4; ext = 1'b1; end
            6'b001011: begin kind = K_I; alu = 5'd8; end
            6'b001100: begin kind = K_I; alu = 5'd5; end
            6'b001101: begin kind = K_I; alu = 5'd6; end
            6'b001110: begin kind = K_I; alu = 5'd7; end
            6'b001111: begin kind = K_I; alu = 5'd2; a = 2'b01; end
            6'b100011: begin kind = K_LW; ext = 1'b1; end
            6'b101011: begin kind = K_SW; ext = 1'b1; end
            6'b000100: begin kind = K_BEQ; alu = 5'd1; end
            6'b000101: begin kind = K_BNE; alu = 5'd1; end
            6'b000010: kind = K_J;
`ifdef MC_CTRL_JAL_EN
            6'b000011: kind = K_JAL;
`endif
            default:   kind = K_ILL;
         endcase
      end
   endfunction

   // A cycle in the given state with every strobe low and don't-care inputs randomized
   function automatic cyc_t blank(input logic [2:0] st);
      cyc_t c;
      c = '0;
      c.ack   = 1'($urandom_range(0, 1));
      c.zero  = 1'($urandom_range(0, 1));
      c.op    = curOp;
      c.funct = curFunct;
      c.o.state = st;
      c.o.err   = modelErr;
      return c;
   endfunction

   task automatic pushReset();
      cyc_t c;
      c = blank(3'd0);
      c.rst = 1'b1;
      c.o   = '0;
      modelErr = 2'b00;
      expq.push_back(c);
   endtask

   task automatic pushErr(input logic [1:0] code);
      cyc_t c;
      modelErr = code;
      for (int i = 0; i < 2; i++) begin
         c = blank(3'd7);
         expq.push_back(c);
      end
      pushReset();
   endtask

   // Expand one instruction into its expected cycle script
   task automatic planInstr(input logic [5:0] op, input logic [5:0] fn, input int ifw,
                            input int memw, input int zf, input bit abortMem);
      cyc_t       c;
      int         kind;
      logic [4:0] alu;
      logic       ext;
      logic [1:0] a;
      curOp = op;
      curFunct = fn;
      expectKind(op, fn, kind, alu, ext, a);
      for (int i = 0; i <= MEM_TO && i <= ifw; i++) begin
         c = blank(3'd0);
         c.ack = (i == ifw);
         c.o.mem_req = 1'b1;
         c.o.alu_src_a = 2'b10;
         c.o.alu_src_b = 2'b01;
         c.o.ir_wr = (i == ifw);
         c.o.pc_wr = (i == ifw);
         expq.push_back(c);
      end
      if (ifw > MEM_TO) begin pushErr(2'b10); return; end
      c = blank(3'd1);
      c.o.alu_src_a = 2'b10;
      c.o.alu_src_b = 2'b11;
      c.o.ext = 1'b1;
      expq.push_back(c);
      if (kind == K_ILL) begin pushErr(2'b01); return; end
      case (kind)
         K_R, K_I, K_LW, K_SW: begin
            c = blank(3'd2);
            c.o.alu_src_a = a;
            c.o.alu_src_b = (kind == K_R) ? 2'b00 : 2'b10;
            c.o.ext = ext;
            c.o.alu_ctrl = alu;
            expq.push_back(c);
            if (kind == K_LW || kind == K_SW) begin
               for (int i = 0; i <= MEM_TO && i <= memw; i++) begin
                  c = blank(3'd3);
                  c.ack = (i == memw);
                  c.o.mem_req = 1'b1;
                  c.o.iord = 1'b1;
                  c.o.mem_wr = (kind == K_SW);
                  if (abortMem) begin
                     c.rst = 1'b1;
                     c.ack = 1'b1;
                     c.o = '0;
                     expq.push_back(c);
                     return;
                  end
                  expq.push_back(c);
               end
               if (memw > MEM_TO) begin pushErr(2'b10); return; end
               if (kind == K_SW) return;
            end
            c = blank(3'd4);
            c.o.reg_wr = 1'b1;
            c.o.reg_dst = (kind == K_R) ? 2'b01 : 2'b00;
            c.o.mem2reg = (kind == K_LW) ? 2'b01 : 2'b00;
            expq.push_back(c);
         end
         K_BEQ, K_BNE: begin
            c = blank(3'd5);
            if (zf >= 0) c.zero = zf[0];
            c.o.alu_ctrl = 5'd1;
            c.o.pc_src = 2'b01;
            c.o.pc_wr = (kind == K_BEQ) ? c.zero : !c.zero;
            expq.push_back(c);
         end
         default: begin
            c = blank(3'd6);
            c.o.pc_wr = 1'b1;
            c.o.pc_src = (kind == K_JR) ? 2'b11 : 2'b10;
            if (kind == K_JAL) begin
               c.o.reg_wr = 1'b1;
               c.o.reg_dst = 2'b10;
               c.o.mem2reg = 2'b10;
            end
            expq.push_back(c);
         end
      endcase
   endtask

   // Drive the queued script, one record per clock, inputs changing just after posedge
   task automatic applyStimulus();
      cyc_t c;
      while (expq.size() > 0) begin
         c = expq.pop_front();
         rst = c.rst;
         bif.mem_ack = c.ack;
         bif.zero = c.zero;
         bif.op = c.op;
         bif.funct = c.funct;
         cur = c;
         curValid = 1'b1;
         @(posedge clk);
         #1;
      end
      curValid = 1'b0;
   endtask

   task automatic checkOutput(input cyc_t c);
      outv_t act;
      act.state = bif.state;       act.err = bif.err;
      act.mem_req = bif.mem_req;   act.iord = bif.iord;       act.mem_wr = bif.mem_wr;
      act.ir_wr = bif.ir_wr;       act.pc_wr = bif.pc_wr;     act.pc_src = bif.pc_src;
      act.reg_wr = bif.reg_wr;     act.reg_dst = bif.reg_dst; act.mem2reg = bif.mem2reg;
      act.alu_src_a = bif.alu_src_a; act.alu_src_b = bif.alu_src_b;
      act.ext = bif.ext;           act.alu_ctrl = bif.alu_ctrl;
      checks++;
      if (act !== c.o) begin
         errors++;
         $display("[TB] FAIL cycle %0d outputs (op=%b funct=%b rst=%b ack=%b): got state=%0d err=%0d vec=%h, want state=%0d err=%0d vec=%h",
                  cycleNo, c.op, c.funct, c.rst, c.ack, act.state, act.err, act, c.o.state, c.o.err, c.o);
      end
   endtask

   task automatic pinCheck(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL model %s: got %0d want %0d", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      cycleNo++;
      if (curValid) checkOutput(cur);
   end

   initial begin
      bif.op = '0; bif.funct = '0; bif.zero = 1'b0; bif.mem_ack = 1'b0;
      @(posedge clk);
      #1;
      pushReset();
      applyStimulus();

      // ADDU, zero-wait memory
      planInstr(6'b000000, 6'b100001, 0, 0, -1, 1'b0);
      pinCheck("addu_len", expq.size(), 4);
      pinCheck("addu_states", int'({expq[0].o.state, expq[1].o.state, expq[2].o.state, expq[3].o.state}), 84);
      pinCheck("addu_wb_regdst", int'(expq[3].o.reg_dst), 1);
      pinCheck("addu_ex_regwr", int'(expq[2].o.reg_wr), 0);
      applyStimulus();

      // LW, three IF waits and two MEM waits
      planInstr(6'b100011, 6'b010101, 3, 2, -1, 1'b0);
      pinCheck("lw_len", expq.size(), 10);
      pinCheck("lw_mem_iord", int'(expq[6].o.iord), 1);
      pinCheck("lw_wb_mem2reg", int'(expq[9].o.mem2reg), 1);
      applyStimulus();

      // Branches with forced zero flag
      planInstr(6'b000101, 6'b000000, 0, 0, 0, 1'b0);
      pinCheck("bne_z0_pcwr", int'(expq[2].o.pc_wr), 1);
      applyStimulus();
      planInstr(6'b000101, 6'b000000, 0, 0, 1, 1'b0);
      pinCheck("bne_z1_pcwr", int'(expq[2].o.pc_wr), 0);
      applyStimulus();
      planInstr(6'b000100, 6'b000000, 0, 0, 1, 1'b0);
      pinCheck("beq_z1_pcwr", int'(expq[2].o.pc_wr), 1);
      applyStimulus();
      planInstr(6'b000100, 6'b000000, 0, 0, 0, 1'b0);
      applyStimulus();

      // Fetch timeout, then ack exactly on the limit cycle
      planInstr(6'b000000, 6'b100000, MEM_TO + 1, 0, -1, 1'b0);
      pinCheck("to_len", expq.size(), 8);
      pinCheck("to_err", int'(expq[5].o.err), 2);
      pinCheck("to_last_req", int'(expq[4].o.mem_req), 1);
      applyStimulus();
      planInstr(6'b100011, 6'b000000, MEM_TO, MEM_TO, -1, 1'b0);
      pinCheck("edge_len", expq.size(), 13);
      applyStimulus();

      // Illegal opcode, JAL, SW aborted by reset while MEM is acknowledged
      planInstr(6'b111111, 6'b000000, 0, 0, -1, 1'b0);
      pinCheck("ill_err", int'(expq[2].o.err), 1);
      applyStimulus();
      planInstr(6'b000011, 6'b000000, 1, 0, -1, 1'b0);
`ifdef MC_CTRL_JAL_EN
      pinCheck("jal_regdst", int'(expq[3].o.reg_dst), 2);
`else
      pinCheck("jal_err", int'(expq[3].o.err), 1);
`endif
      applyStimulus();
      planInstr(6'b101011, 6'b000000, 0, 0, -1, 1'b1);
      applyStimulus();

      // Random instruction stream
      for (int n = 0; n < 200; n++) begin
         logic [5:0] op, fn;
         int ifw, memw;
         op = opTab[$urandom_range(0, 17)];
         fn = fnTab[$urandom_range(0, 15)];
         ifw = ($urandom_range(0, 19) == 0) ? MEM_TO + 1 : $urandom_range(0, MEM_TO);
         memw = ($urandom_range(0, 19) == 0) ? MEM_TO + 1 : $urandom_range(0, MEM_TO);
         planInstr(op, fn, ifw, memw, -1, 1'b0);
         applyStimulus();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
